// File: rtl/pipe_control_unit.sv
// Control unit for a 5-stage MIPS pipeline: ID decode, stall/flush generation and D->E->M->W control registers.
// Define PIPE_CTRL_FORWARD_EN to add operand forwarding selects (fwdA_E/fwdB_E) and relax RAW stalls.
module pipe_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4,
  parameter int NPC_OP_W   = 2,
  parameter int LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcodeD,
  input  logic [5:0]            funcD,
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  isRsRtEq,
  output logic [NPC_OP_W-1:0]   npcOpD,
  output logic [1:0]            extOpD,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  illegalD,
  output logic [ALU_OP_W-1:0]   aluOpE,
  output logic                  aluSrc_muxE,
  output logic [REG_ADDR_W-1:0] writeRegE,
  output logic [REG_ADDR_W-1:0] writeRegM,
  output logic [REG_ADDR_W-1:0] writeRegW,
  output logic                  DataMem_weM,
  output logic                  Regfile_weW,
`ifdef PIPE_CTRL_FORWARD_EN
  output logic [1:0]            fwdA_E,
  output logic [1:0]            fwdB_E,
`endif
  output logic [1:0]            regSrc_muxW
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_LUI = ALU_OP_W'(5);

  localparam logic [NPC_OP_W-1:0] NPC_SEQ    = NPC_OP_W'(0);
  localparam logic [NPC_OP_W-1:0] NPC_BRANCH = NPC_OP_W'(1);
  localparam logic [NPC_OP_W-1:0] NPC_JUMP   = NPC_OP_W'(2);

  localparam logic [REG_ADDR_W-1:0] LINK_IDX = REG_ADDR_W'(LINK_REG);

  typedef enum logic [1:0] {EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2} ext_e;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_LINK = 2'd2} src_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  alu_src;
    logic                  mem_we;
    logic                  rf_we;
    src_e                  reg_src;
    logic [REG_ADDR_W-1:0] write_reg;
  } ctrl_e_t;

  typedef struct packed {
    logic                  mem_we;
    logic                  rf_we;
    src_e                  reg_src;
    logic [REG_ADDR_W-1:0] write_reg;
  } ctrl_m_t;

  typedef struct packed {
    logic                  rf_we;
    src_e                  reg_src;
    logic [REG_ADDR_W-1:0] write_reg;
  } ctrl_w_t;

  ctrl_e_t e_q, e_d, dec_ctrl;
  ctrl_m_t m_q, m_d;
  ctrl_w_t w_q, w_d;

  ext_e                ext_op;
  logic [NPC_OP_W-1:0] npc_raw;
  logic                reads_rt;
  logic                is_beq;
  logic                illegal;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no decode path can infer a latch.
    dec_ctrl = '0;
    ext_op   = EXT_ZERO;
    npc_raw  = NPC_SEQ;
    reads_rt = 1'b0;
    is_beq   = 1'b0;
    illegal  = 1'b0;
    case (opcodeD)
      OP_RTYPE: begin
        reads_rt           = 1'b1;
        dec_ctrl.rf_we     = 1'b1;
        dec_ctrl.write_reg = rdD;
        case (funcD)
          FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
          FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
          FN_AND:  dec_ctrl.alu_op = ALU_AND;
          FN_OR:   dec_ctrl.alu_op = ALU_OR;
          FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        dec_ctrl.alu_op    = ALU_OR;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.rf_we     = 1'b1;
        dec_ctrl.write_reg = rtD;
      end
      OP_LUI: begin
        ext_op             = EXT_LUI;
        dec_ctrl.alu_op    = ALU_LUI;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.rf_we     = 1'b1;
        dec_ctrl.write_reg = rtD;
      end
      OP_LW: begin
        ext_op             = EXT_SIGN;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.rf_we     = 1'b1;
        dec_ctrl.reg_src   = SRC_MEM;
        dec_ctrl.write_reg = rtD;
      end
      OP_SW: begin
        ext_op           = EXT_SIGN;
        reads_rt         = 1'b1;
        dec_ctrl.alu_op  = ALU_ADD;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mem_we  = 1'b1;
      end
      OP_BEQ: begin
        ext_op          = EXT_SIGN;
        reads_rt        = 1'b1;
        is_beq          = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        npc_raw         = isRsRtEq ? NPC_BRANCH : NPC_SEQ;
      end
      OP_J: npc_raw = NPC_JUMP;
      OP_JAL: begin
        npc_raw            = NPC_JUMP;
        dec_ctrl.rf_we     = 1'b1;
        dec_ctrl.reg_src   = SRC_LINK;
        dec_ctrl.write_reg = LINK_IDX;
      end
      default: illegal = 1'b1;
    endcase
    // Unknown encodings travel down the pipe as a NOP and read nothing through rt.
    if (illegal) begin
      dec_ctrl = '0;
      reads_rt = 1'b0;
    end
  end

  function automatic logic writes_src(input logic we, input logic [REG_ADDR_W-1:0] dst,
                                      input logic [REG_ADDR_W-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  logic rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
  logic hazard, stall;

  assign rs_hit_e = writes_src(e_q.rf_we, e_q.write_reg, rsD);
  assign rt_hit_e = reads_rt && writes_src(e_q.rf_we, e_q.write_reg, rtD);
  assign rs_hit_m = writes_src(m_q.rf_we, m_q.write_reg, rsD);
  assign rt_hit_m = reads_rt && writes_src(m_q.rf_we, m_q.write_reg, rtD);

`ifdef PIPE_CTRL_FORWARD_EN
  logic e_is_load, m_is_load, load_use, branch_haz;

  assign e_is_load  = e_q.rf_we && (e_q.reg_src == SRC_MEM);
  assign m_is_load  = m_q.rf_we && (m_q.reg_src == SRC_MEM);
  assign load_use   = e_is_load && (rs_hit_e || rt_hit_e);
  // The branch compare sits in ID, so it cannot take EX results or load data still in MEM.
  assign branch_haz = is_beq && (rs_hit_e || rt_hit_e || (m_is_load && (rs_hit_m || rt_hit_m)));
  assign hazard     = load_use || branch_haz;
`else
  // The register file writes in the first half-cycle, so only E and M writers need to be waited out.
  assign hazard = rs_hit_e || rt_hit_e || rs_hit_m || rt_hit_m;
  logic unused_is_beq;
  assign unused_is_beq = is_beq;
`endif

  assign stall    = !rst && hazard;
  assign stallF   = stall;
  assign stallD   = stall;
  assign npcOpD   = (rst || stall) ? NPC_SEQ : npc_raw;
  assign flushD   = (npcOpD != NPC_SEQ);
  assign illegalD = !rst && illegal;
  assign extOpD   = rst ? EXT_ZERO : ext_op;

  assign e_d = stall ? '0 : dec_ctrl;
  assign m_d = '{mem_we: e_q.mem_we, rf_we: e_q.rf_we, reg_src: e_q.reg_src, write_reg: e_q.write_reg};
  assign w_d = '{rf_we: m_q.rf_we, reg_src: m_q.reg_src, write_reg: m_q.write_reg};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage sample its predecessor's pre-edge value.
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign aluOpE      = e_q.alu_op;
  assign aluSrc_muxE = e_q.alu_src;
  assign writeRegE   = e_q.write_reg;
  assign writeRegM   = m_q.write_reg;
  assign DataMem_weM = m_q.mem_we;
  assign writeRegW   = w_q.write_reg;
  assign Regfile_weW = w_q.rf_we;
  assign regSrc_muxW = w_q.reg_src;

`ifdef PIPE_CTRL_FORWARD_EN
  logic [REG_ADDR_W-1:0] rs_e_q, rt_e_q;

  always_ff @(posedge clk) begin
    if (rst || stall) begin
      rs_e_q <= '0;
      rt_e_q <= '0;
    end else begin
      rs_e_q <= rsD;
      rt_e_q <= rtD;
    end
  end

  // M holds the younger result, so it wins when both later stages write the same register.
  always_comb begin
    fwdA_E = 2'd0;
    fwdB_E = 2'd0;
    if (writes_src(m_q.rf_we, m_q.write_reg, rs_e_q))      fwdA_E = 2'd2;
    else if (writes_src(w_q.rf_we, w_q.write_reg, rs_e_q)) fwdA_E = 2'd1;
    if (writes_src(m_q.rf_we, m_q.write_reg, rt_e_q))      fwdB_E = 2'd2;
    else if (writes_src(w_q.rf_we, w_q.write_reg, rt_e_q)) fwdB_E = 2'd1;
  end
`endif

endmodule
